control_unit_pc: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 58 +++++
 rtl/ctrl_decoder.sv | 70 +++++++
 rtl/control_unit_pc.sv | 35 +++
 tb/tb_control_unit_pc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the MIPS ID-stage control path: opcodes, functs,
// operand/ALU/size codes and the bit layout of the 21-bit control word.
package cpu_ctrl_pkg;

  localparam int CTRL_W = 21;
  typedef logic [CTRL_W-1:0] ctrl_word_t;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SB    = 6'b101000;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_PASS_B = 4'b0010,
    ALU_PASS_A = 4'b0011
  } alu_op_e;

  typedef enum logic [2:0] {
    OPND_RT      = 3'b000,
    OPND_SE_IMM  = 3'b001,
    OPND_ZE_IMM  = 3'b010,
    OPND_IMM_HI  = 3'b011
  } shift_imm_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_e;

  // Control-word bit positions
  localparam int MEM_WRITE_BIT     = 20;
  localparam int RT_DEST_BIT       = 19;
  localparam int SHIFT_IMM_LSB     = 16;
  localparam int ALU_OP_LSB        = 12;
  localparam int LOAD_INSTR_BIT    = 11;
  localparam int RF_ENABLE_BIT     = 10;
  localparam int BRANCH_ENABLE_BIT = 9;
  localparam int JUMP_ENABLE_BIT   = 8;
  localparam int R31_DEST_BIT      = 7;
  localparam int HI_ENABLE_BIT     = 6;
  localparam int LO_ENABLE_BIT     = 5;
  localparam int SIZE_LSB          = 3;
  localparam int MEM_DATA_SE_BIT   = 2;
  localparam int MEM_DATA_EN_BIT   = 1;
  localparam int PC_PLUS_8_BIT     = 0;

endpackage

// File: rtl/ctrl_decoder.sv
// Pure combinational opcode/funct decoder producing the 21-bit control word.
module ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] control_raw
);

  ctrl_word_t ctrl;

  always_comb begin
    // NOTE: default every field first so unlisted encodings decode to NOP and no latch is inferred.
    ctrl = '0;
    unique case (opcode)
      OP_ADDIU: begin
        ctrl[RT_DEST_BIT]               = 1'b1;
        ctrl[SHIFT_IMM_LSB +: 3]        = OPND_SE_IMM;
        ctrl[ALU_OP_LSB +: 4]           = ALU_ADD;
        ctrl[RF_ENABLE_BIT]             = 1'b1;
      end
      OP_LBU: begin
        ctrl[RT_DEST_BIT]               = 1'b1;
        ctrl[SHIFT_IMM_LSB +: 3]        = OPND_SE_IMM;
        ctrl[ALU_OP_LSB +: 4]           = ALU_ADD;
        ctrl[LOAD_INSTR_BIT]            = 1'b1;
        ctrl[RF_ENABLE_BIT]             = 1'b1;
        ctrl[SIZE_LSB +: 2]             = SIZE_BYTE;
        ctrl[MEM_DATA_EN_BIT]           = 1'b1;
      end
      OP_SB: begin
        ctrl[MEM_WRITE_BIT]             = 1'b1;
        ctrl[SHIFT_IMM_LSB +: 3]        = OPND_SE_IMM;
        ctrl[ALU_OP_LSB +: 4]           = ALU_ADD;
        ctrl[SIZE_LSB +: 2]             = SIZE_BYTE;
        ctrl[MEM_DATA_EN_BIT]           = 1'b1;
      end
      OP_BGTZ: begin
        ctrl[BRANCH_ENABLE_BIT]         = 1'b1;
        ctrl[ALU_OP_LSB +: 4]           = ALU_PASS_A;
      end
      OP_LUI: begin
        ctrl[RT_DEST_BIT]               = 1'b1;
        ctrl[SHIFT_IMM_LSB +: 3]        = OPND_IMM_HI;
        ctrl[ALU_OP_LSB +: 4]           = ALU_PASS_B;
        ctrl[RF_ENABLE_BIT]             = 1'b1;
      end
      OP_JAL: begin
        ctrl[JUMP_ENABLE_BIT]           = 1'b1;
        ctrl[R31_DEST_BIT]              = 1'b1;
        ctrl[RF_ENABLE_BIT]             = 1'b1;
        ctrl[PC_PLUS_8_BIT]             = 1'b1;
      end
      OP_RTYPE: begin
        unique case (funct)
          FN_SUBU: begin
            ctrl[ALU_OP_LSB +: 4]       = ALU_SUB;
            ctrl[RF_ENABLE_BIT]         = 1'b1;
          end
          FN_JR:   ctrl[JUMP_ENABLE_BIT] = 1'b1;
          default: ctrl = '0;
        endcase
      end
      default: ctrl = '0;
    endcase
  end

  assign control_raw = ctrl;

endmodule

// File: rtl/control_unit_pc.sv
// ID-stage control path: program counter register, instruction decode and
// the hazard NOP mux feeding the ID/EX register.
module control_unit_pc
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_enable,
  input  logic [31:0]       pc_in,
  output logic [31:0]       pc_out,
  input  logic [31:0]       instruction,
  input  logic              nop_sel,
  output logic [CTRL_W-1:0] control_raw,
  output logic [CTRL_W-1:0] control_signal
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          pc_out <= '0;
    else if (pc_enable) pc_out <= pc_in;
  end

  ctrl_decoder u_ctrl_decoder (
    .opcode      (instruction[31:26]),
    .funct       (instruction[5:0]),
    .control_raw (control_raw)
  );

  // Register fields and shamt are consumed downstream, not by the decoder.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[25:6];

  assign control_signal = nop_sel ? '0 : control_raw;

endmodule

// File: tb/tb_control_unit_pc.sv
// Self-checking bench for control_unit_pc: directed cases from the test plan
// plus randomized decode and PC traffic against a behavioural model.
module tb_control_unit_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_enable;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        nop_sel;
  logic [20:0] control_raw;
  logic [20:0] control_signal;

  int n_cmp = 0;
  int n_err = 0;

  control_unit_pc dut (
    .clk            (clk),
    .reset          (reset),
    .pc_enable      (pc_enable),
    .pc_in          (pc_in),
    .pc_out         (pc_out),
    .instruction    (instruction),
    .nop_sel        (nop_sel),
    .control_raw    (control_raw),
    .control_signal (control_signal)
  );

  always #5 clk = ~clk;

  // Reference decode: instruction -> control word, straight from the opcode table.
  function automatic logic [20:0] ref_decode(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    case (op)
      6'b001001: return 21'h090400;
      6'b100100: return 21'h090C02;
      6'b101000: return 21'h110002;
      6'b000111: return 21'h003200;
      6'b001111: return 21'h0B2400;
      6'b000011: return 21'h000581;
      6'b000000: begin
        if (fn == 6'b100011) return 21'h001400;
        if (fn == 6'b001000) return 21'h000100;
        return 21'h000000;
      end
      default:   return 21'h000000;
    endcase
  endfunction

  task automatic cmp_pc(input string name, input logic [31:0] exp);
    n_cmp++;
    if (pc_out !== exp) begin
      n_err++;
      $display("FAIL %s: pc_out got %h expected %h", name, pc_out, exp);
    end
  endtask

  task automatic cmp_ctrl(input string name, input logic [20:0] exp_raw, input logic [20:0] exp_sig);
    n_cmp++;
    if (control_raw !== exp_raw) begin
      n_err++;
      $display("FAIL %s: control_raw got %h expected %h (instr %h)", name, control_raw, exp_raw, instruction);
    end
    n_cmp++;
    if (control_signal !== exp_sig) begin
      n_err++;
      $display("FAIL %s: control_signal got %h expected %h (instr %h nop %b)", name, control_signal, exp_sig, instruction, nop_sel);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_enable = 1'b1; pc_in = 32'h40; instruction = '0; nop_sel = 1'b0;
    #2;
    cmp_pc("reset_async", 32'h0);
    cmp_ctrl("reset_ctrl", 21'h0, 21'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    cmp_pc("reset_release_load", 32'h40);
  endtask

  task automatic test_pc_enable();
    @(negedge clk);
    pc_enable = 1'b0; pc_in = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp_pc("pc_hold", 32'h40);
    end
    @(negedge clk);
    pc_enable = 1'b1;
    tick();
    cmp_pc("pc_reenable", 32'h8);
  endtask

  task automatic test_async_reset_mid();
    @(negedge clk);
    pc_in = 32'hFFFF_FFFC;
    tick();
    cmp_pc("pc_load_max", 32'hFFFF_FFFC);
    #2;
    reset = 1'b1;
    #1;
    cmp_pc("reset_mid_cycle", 32'h0);
    @(negedge clk);
    reset = 1'b0; pc_in = 32'h1234_5678;
    tick();
    cmp_pc("reset_mid_release", 32'h1234_5678);
  endtask

  task automatic test_decode_sweep();
    logic [31:0] instrs [8] = '{32'h24010005, 32'h90A20000, 32'hA0A20000, 32'h1C200003,
                                32'h3C011234, 32'h0C000010, 32'h00221823, 32'h03E00008};
    logic [20:0] exps [8]   = '{21'h090400, 21'h090C02, 21'h110002, 21'h003200,
                                21'h0B2400, 21'h000581, 21'h001400, 21'h000100};
    nop_sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      instruction = instrs[i];
      #1;
      cmp_ctrl("decode_sweep", exps[i], exps[i]);
    end
  endtask

  task automatic test_unknown();
    nop_sel = 1'b0;
    instruction = 32'h0000_0000;
    #1;
    cmp_ctrl("decode_zero", 21'h0, 21'h0);
    instruction = 32'hFC00_0000 | 32'h0012_3456;
    #1;
    cmp_ctrl("decode_op3f", 21'h0, 21'h0);
    instruction = 32'h0022_1821;  // R-type with unhandled funct
    #1;
    cmp_ctrl("decode_rtype_other", 21'h0, 21'h0);
  endtask

  task automatic test_nop_override();
    instruction = 32'h24010005;
    nop_sel = 1'b1;
    #1;
    cmp_ctrl("nop_forced", 21'h090400, 21'h0);
    nop_sel = 1'b0;
    #1;
    cmp_ctrl("nop_dropped", 21'h090400, 21'h090400);
  endtask

  task automatic test_random_decode();
    logic [5:0] ops [8] = '{6'b001001, 6'b100100, 6'b101000, 6'b000111,
                            6'b001111, 6'b000011, 6'b000000, 6'b000000};
    logic [31:0] w;
    logic [20:0] e;
    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        w[31:26] = ops[$urandom_range(0, 7)];
        if (w[31:26] == 6'b000000 && $urandom_range(0, 2) != 0)
          w[5:0] = $urandom_range(0, 1) ? 6'b100011 : 6'b001000;
      end
      instruction = w;
      nop_sel = ($urandom_range(0, 3) == 0);
      #1;
      e = ref_decode(w);
      cmp_ctrl("random_decode", e, nop_sel ? 21'h0 : e);
    end
  endtask

  task automatic test_random_pc();
    logic [31:0] model_pc;
    model_pc = pc_out === 32'h1234_5678 ? 32'h1234_5678 : 32'hx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      pc_enable = $urandom_range(0, 1);
      pc_in = $urandom;
      if (pc_enable) model_pc = pc_in;
      tick();
      cmp_pc("random_pc", model_pc);
    end
  endtask

  initial begin
    test_reset();
    test_pc_enable();
    test_async_reset_mid();
    test_decode_sweep();
    test_unknown();
    test_nop_override();
    test_random_decode();
    test_random_pc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
